// File: rtl/pe_drain_pkg.sv
`default_nettype none
// ============================================================================
// pe_drain_pkg
//   Shared types, default sizes and helpers for the PE output drain.
//   Rev 1.0 - initial release
// ============================================================================
package pe_drain_pkg;

  localparam int N_PE_DEF    = 8;
  localparam int WID_PE_DEF  = 16;
  localparam int LANE_IDX_W  = (N_PE_DEF > 1) ? $clog2(N_PE_DEF) : 1;
  localparam int CNT_W       = $clog2(N_PE_DEF + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

  // Requested lane count saturated to the number of physical lanes.
  function automatic int unsigned clamp_cnt(input int unsigned cnt, input int unsigned lim);
    return (cnt > lim) ? lim : cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_drain_bank.sv
`default_nettype none
// ============================================================================
// pe_drain_bank
//   One row of captured lane words with its lane count and a full flag.
//   Word selected for output by a lane index.
//   Rev 1.0 - initial release
// ============================================================================
module pe_drain_bank
  import pe_drain_pkg::*;
#(
  parameter int N_LANES = N_PE_DEF,
  parameter int WID     = WID_PE_DEF,
  parameter int IDX_W   = LANE_IDX_W,
  parameter int CW      = CNT_W
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   we_i,
  input  logic                   set_full_i,
  input  logic [N_LANES*WID-1:0] data_i,
  input  logic [CW-1:0]          count_i,
  input  logic                   clr_i,
  input  logic [IDX_W-1:0]       rd_idx_i,
  output logic [WID-1:0]         rd_data_o,
  output logic [CW-1:0]          count_o,
  output logic                   full_o
);

  logic [WID-1:0] data_q [N_LANES];
  logic [CW-1:0]  count_q;
  logic           full_q;

  // Capture a whole row on write; a write wins over a simultaneous release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_LANES; i++) data_q[i] <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else if (we_i) begin
      for (int i = 0; i < N_LANES; i++) data_q[i] <= data_i[i*WID +: WID];
      count_q <= count_i;
      full_q  <= set_full_i;
    end else if (clr_i) begin
      full_q <= 1'b0;
    end
  end

  assign rd_data_o = data_q[rd_idx_i];
  assign count_o   = count_q;
  assign full_o    = full_q;

endmodule
`default_nettype wire

// File: rtl/pe_out_drain.sv
`default_nettype none
// ============================================================================
// pe_out_drain
//   Captures one row of PE lane results and writes them one word per
//   handshake into the output buffer at auto-incrementing addresses.
//   Build option: PE_DRAIN_DBLBUF_EN selects two ping-pong capture banks.
//   Rev 1.0 - initial release
// ============================================================================
module pe_out_drain
  import pe_drain_pkg::*;
#(
  parameter int N_LANES = N_PE_DEF,
  parameter int WID     = WID_PE_DEF,
  parameter int ADDR_W  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         cap_valid_i,
  output logic                         cap_ready_o,
  input  logic [N_LANES*WID-1:0]       cap_data_i,
  input  logic [$clog2(N_LANES+1)-1:0] cap_count_i,
  input  logic                         frame_start_i,
  input  logic [ADDR_W-1:0]            base_addr_i,
  output logic                         wr_valid_o,
  input  logic                         wr_ready_i,
  output logic [ADDR_W-1:0]            wr_addr_o,
  output logic [WID-1:0]               wr_data_o,
  output logic                         row_done_o,
  output logic                         busy_o
);

  localparam int IDX_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int CW    = $clog2(N_LANES + 1);
`ifdef PE_DRAIN_DBLBUF_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  drain_state_e         state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [ADDR_W-1:0]    ptr_q;
  logic [ADDR_W-1:0]    pend_base_q;
  logic                 pend_q;
  logic                 row_done_q;

  logic                 rsel;        // bank being drained
  logic                 wsel;        // bank receiving the next capture
  logic [1:0]           full_w;
  logic [1:0][CW-1:0]   cnt_w;
  logic [1:0][WID-1:0]  rdata_w;
  logic [CW-1:0]        cap_cnt;
  logic                 cap_fire;
  logic                 set_full;
  logic                 accept;
  logic                 last_acc;
  logic                 retire;
  logic                 cont;        // another non-empty row follows without a bubble

  assign cap_cnt     = CW'(clamp_cnt(32'(cap_count_i), N_LANES));
  assign cap_ready_o = !full_w[wsel];
  assign cap_fire    = cap_valid_i && cap_ready_o;
  // An empty row captured while nothing is queued retires at once instead of occupying a bank.
  assign set_full    = (state_q != IDLE) || full_w[rsel] || (cap_cnt != '0);
  assign accept      = (state_q == DRAIN) && wr_ready_i;
  assign last_acc    = accept && ((CW'(idx_q) + CW'(1)) == cnt_w[rsel]);
  // A queued empty row retires in IDLE, one gap cycle after any preceding row_done.
  assign retire      = (state_q == IDLE) && full_w[rsel] && (cnt_w[rsel] == '0) && !row_done_q;

  for (genvar gb = 0; gb < NB; gb++) begin : g_bank
    logic we;
    logic clr;
    assign we  = cap_fire && (wsel == 1'(gb));
    assign clr = (last_acc || retire) && (rsel == 1'(gb));

    pe_drain_bank #(
      .N_LANES (N_LANES),
      .WID     (WID),
      .IDX_W   (IDX_W),
      .CW      (CW)
    ) u_bank (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .we_i       (we),
      .set_full_i (set_full),
      .data_i     (cap_data_i),
      .count_i    (cap_cnt),
      .clr_i      (clr),
      .rd_idx_i   (idx_q),
      .rd_data_o  (rdata_w[gb]),
      .count_o    (cnt_w[gb]),
      .full_o     (full_w[gb])
    );
  end

  if (NB == 1) begin : g_tie
    assign full_w[1]  = 1'b0;
    assign cnt_w[1]   = '0;
    assign rdata_w[1] = '0;
  end

`ifdef PE_DRAIN_DBLBUF_EN
  logic rsel_q;
  logic wsel_q;

  assign rsel = rsel_q;
  assign wsel = wsel_q;
  // During a drain any capture lands in the other bank, so it can be chained directly.
  assign cont = (full_w[~rsel_q] && (cnt_w[~rsel_q] != '0)) || (cap_fire && (cap_cnt != '0));

  // Ping-pong pointers: read side advances per retired row, write side per stored row.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsel_q <= 1'b0;
      wsel_q <= 1'b0;
    end else begin
      if (last_acc || retire) rsel_q <= ~rsel_q;
      if (cap_fire && set_full) wsel_q <= ~wsel_q;
    end
  end
`else
  assign rsel = 1'b0;
  assign wsel = 1'b0;
  assign cont = 1'b0;
`endif

  // Drain FSM with write pointer, deferred frame reload and row_done pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      ptr_q       <= '0;
      pend_base_q <= '0;
      pend_q      <= 1'b0;
      row_done_q  <= 1'b0;
    end else begin
      row_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame_start_i) ptr_q <= base_addr_i;
          if (full_w[rsel]) begin
            if (cnt_w[rsel] == '0) begin
              if (!row_done_q) row_done_q <= 1'b1;
            end else begin
              state_q <= DRAIN;
              idx_q   <= '0;
            end
          end else if (cap_fire) begin
            if (cap_cnt == '0) begin
              row_done_q <= 1'b1;
            end else begin
              state_q <= DRAIN;
              idx_q   <= '0;
            end
          end
        end
        DRAIN: begin
          if (frame_start_i && !last_acc) begin
            pend_q      <= 1'b1;
            pend_base_q <= base_addr_i;
          end
          if (accept) begin
            idx_q <= idx_q + IDX_W'(1);
            ptr_q <= ptr_q + ADDR_W'(1);
            if (last_acc) begin
              row_done_q <= 1'b1;
              idx_q      <= '0;
              pend_q     <= 1'b0;
              if (frame_start_i)  ptr_q <= base_addr_i;
              else if (pend_q)    ptr_q <= pend_base_q;
              if (!cont) state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_valid_o = (state_q == DRAIN);
  assign wr_addr_o  = ptr_q;
  assign wr_data_o  = rdata_w[rsel];
  assign row_done_o = row_done_q;
  assign busy_o     = (state_q != IDLE) || (|full_w);

endmodule
`default_nettype wire

// File: tb/tb_pe_out_drain.sv
`default_nettype none
// ============================================================================
// tb_pe_out_drain
//   Directed bench for pe_out_drain (8 lanes x 16 bits, 16-bit addresses).
//   Rev 1.0 - initial release
// ============================================================================
module tb_pe_out_drain;

  localparam int NL = 8;
  localparam int WD = 16;
  localparam int AW = 16;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic            cap_valid_i = 1'b0;
  logic            cap_ready_o;
  logic [NL*WD-1:0] cap_data_i = '0;
  logic [CW-1:0]   cap_count_i = '0;
  logic            frame_start_i = 1'b0;
  logic [AW-1:0]   base_addr_i = '0;
  logic            wr_valid_o;
  logic            wr_ready_i = 1'b1;
  logic [AW-1:0]   wr_addr_o;
  logic [WD-1:0]   wr_data_o;
  logic            row_done_o;
  logic            busy_o;

  pe_out_drain #(.N_LANES(NL), .WID(WD), .ADDR_W(AW)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .cap_valid_i   (cap_valid_i),
    .cap_ready_o   (cap_ready_o),
    .cap_data_i    (cap_data_i),
    .cap_count_i   (cap_count_i),
    .frame_start_i (frame_start_i),
    .base_addr_i   (base_addr_i),
    .wr_valid_o    (wr_valid_o),
    .wr_ready_i    (wr_ready_i),
    .wr_addr_o     (wr_addr_o),
    .wr_data_o     (wr_data_o),
    .row_done_o    (row_done_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int rd_cnt = 0;
  int rd_cyc = -1;
  logic [AW-1:0] wq_addr [$];
  logic [WD-1:0] wq_data [$];
  int            wq_cyc  [$];
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [WD-1:0] prev_data = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Write/row_done logger plus hold check for stalled words.
  always @(negedge clk) begin
    if (prev_stall)
      check_val("stall_hold", {wr_valid_o, wr_addr_o, wr_data_o}, {1'b1, prev_addr, prev_data});
    prev_stall = wr_valid_o && !wr_ready_i;
    prev_addr  = wr_addr_o;
    prev_data  = wr_data_o;
    if (wr_valid_o && wr_ready_i) begin
      wq_addr.push_back(wr_addr_o);
      wq_data.push_back(wr_data_o);
      wq_cyc.push_back(cyc);
    end
    if (row_done_o) begin
      rd_cnt++;
      rd_cyc = cyc;
    end
  end

  function automatic logic [NL*WD-1:0] pack(input logic [WD-1:0] s);
    logic [NL*WD-1:0] r;
    for (int i = 0; i < NL; i++) r[i*WD +: WD] = s + WD'(i);
    return r;
  endfunction

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
    rd_cnt = 0;
  endtask

  task automatic frame(input logic [AW-1:0] b);
    frame_start_i = 1'b1;
    base_addr_i   = b;
    @(posedge clk); #1;
    frame_start_i = 1'b0;
  endtask

  task automatic capture(input logic [NL*WD-1:0] d, input int cnt);
    bit done = 1'b0;
    cap_data_i  = d;
    cap_count_i = CW'(cnt);
    cap_valid_i = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (cap_ready_o) done = 1'b1;
    end
    check_val("cap_accepted", done, 1);
    @(posedge clk); #1;
    cap_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy_o && !wr_valid_o) break;
    end
    check_val({tag, "_idle"}, busy_o, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic expect_writes(input string tag, input int n, input logic [AW-1:0] a0,
                               input logic [WD-1:0] d0);
    logic [AW-1:0] ea;
    logic [WD-1:0] ed;
    check_val({tag, "_nwr"}, wq_addr.size(), n);
    for (int j = 0; j < n && j < wq_addr.size(); j++) begin
      ea = a0 + AW'(j);
      ed = d0 + WD'(j);
      check_val($sformatf("%s_addr%0d", tag, j), wq_addr[j], ea);
      check_val($sformatf("%s_data%0d", tag, j), wq_data[j], ed);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  bit [0:3] pat = 4'b1001;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_cap_ready", cap_ready_o, 1);
    check_val("rst_wr_valid",  wr_valid_o, 0);
    check_val("rst_wr_addr",   wr_addr_o, 0);
    check_val("rst_wr_data",   wr_data_o, 0);
    check_val("rst_row_done",  row_done_o, 0);
    check_val("rst_busy",      busy_o, 0);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // 1: basic 4-lane row at 0x100
    frame(16'h0100);
    clear_log();
    capture(pack(16'h0001), 4);
    @(negedge clk);
    check_val("t1_lat_valid", wr_valid_o, 1);
    check_val("t1_lat_addr",  wr_addr_o, 16'h0100);
    check_val("t1_lat_data",  wr_data_o, 16'h0001);
    wait_idle("t1");
    expect_writes("t1", 4, 16'h0100, 16'h0001);
    check_val("t1_row_done_cnt", rd_cnt, 1);
    if (wq_cyc.size() > 0)
      check_val("t1_row_done_lat", rd_cyc, wq_cyc[wq_cyc.size()-1] + 1);

    // 2: same shape with wr_ready 1-0-0-1
    clear_log();
    capture(pack(16'h0020), 4);
    for (int k = 1; k < 25; k++) begin
      wr_ready_i = pat[k % 4];
      @(posedge clk); #1;
    end
    wr_ready_i = 1'b1;
    wait_idle("t2");
    expect_writes("t2", 4, 16'h0104, 16'h0020);
    check_val("t2_row_done_cnt", rd_cnt, 1);

    // 3: frame_start mid-drain takes effect on the next row
    frame(16'h0010);
    clear_log();
    capture(pack(16'h0030), 8);
    @(posedge clk); #1;
    frame(16'h0200);
    base_addr_i = 16'h0BAD;
    wait_idle("t3a");
    expect_writes("t3a", 8, 16'h0010, 16'h0030);
    clear_log();
    capture(pack(16'h0040), 2);
    wait_idle("t3b");
    expect_writes("t3b", 2, 16'h0200, 16'h0040);

    // 4: empty row, then over-long row clamped to 8 lanes
    clear_log();
    capture(pack(16'h0050), 0);
    wait_idle("t4a");
    expect_writes("t4a", 0, 16'h0000, 16'h0000);
    check_val("t4a_row_done_cnt", rd_cnt, 1);
    clear_log();
    capture(pack(16'h0060), NL + 3);
    wait_idle("t4b");
    expect_writes("t4b", 8, 16'h0202, 16'h0060);
    check_val("t4b_row_done_cnt", rd_cnt, 1);

    // 5: address wrap
    frame(16'hFFFE);
    clear_log();
    capture(pack(16'h0070), 4);
    wait_idle("t5");
    expect_writes("t5", 4, 16'hFFFE, 16'h0070);

`ifdef PE_DRAIN_DBLBUF_EN
    // 6: back-to-back rows through both banks with no bubble
    clear_log();
    capture(pack(16'h0080), 4);
    capture(pack(16'h0090), 4);
    @(negedge clk);
    check_val("t6_cap_ready_both_full", cap_ready_o, 0);
    check_val("t6_busy", busy_o, 1);
    wait_idle("t6");
    check_val("t6_nwr", wq_addr.size(), 8);
    if (wq_addr.size() == 8) begin
      check_val("t6_span",  wq_cyc[7] - wq_cyc[0], 7);
      check_val("t6_addr0", wq_addr[0], 16'h0002);
      check_val("t6_data3", wq_data[3], 16'h0083);
      check_val("t6_data4", wq_data[4], 16'h0090);
      check_val("t6_addr7", wq_addr[7], 16'h0009);
      check_val("t6_data7", wq_data[7], 16'h0093);
    end
    check_val("t6_row_done_cnt", rd_cnt, 2);
`endif

    // 7: asynchronous reset in the middle of a drain
    clear_log();
    capture(pack(16'h00A0), 8);
    @(posedge clk); #2;
    rst_ni = 1'b0;
    #1;
    check_val("t7_wr_valid",  wr_valid_o, 0);
    check_val("t7_wr_addr",   wr_addr_o, 0);
    check_val("t7_wr_data",   wr_data_o, 0);
    check_val("t7_busy",      busy_o, 0);
    check_val("t7_cap_ready", cap_ready_o, 1);
    check_val("t7_row_done",  row_done_o, 0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("t7_post_valid", wr_valid_o, 0);
    check_val("t7_post_busy",  busy_o, 0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
